seg7_scan: RTL

Parametrised, time-multiplexed hexadecimal seven-segment display driver. It latches a packed multi-digit value, decodes each 4-bit nibble to hex glyphs 0-F, and scans the digits one at a time onto a shared active-low segment bus with one-hot active-low anode enables. Optional leading-zero blanking is supported. It sits between the datapath (UART receiver / counters) and the board display pins, and supersedes the single-digit decimal decoder.

---
 rtl/seg7_scan.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex seven-segment driver with a double-buffered display value.
// Define SEG7_BLINK_EN to add the per-digit blink input and the BLINK_FRAMES blink-rate parameter.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
`ifdef SEG7_BLINK_EN
    input  logic [DIGITS-1:0]   blink,
`endif
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  tick, wrap, all_zero, blink_off;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_lz;

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0]         frm_q, frm_d;
    logic                  phase_on_q, phase_on_d;
    logic                  cur_blink;
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        tick      = (cnt_q == CNT_LAST);
        wrap      = tick && (idx_q == IDX_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load landing on the wrap bypasses the shadow so it is not delayed a whole frame.
        if (load && wrap) begin
            active_d  = value;
            shadow_d  = value;
            pending_d = 1'b0;
        end else begin
            if (wrap && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            if (load) begin
                shadow_d  = value;
                pending_d = 1'b1;
            end
        end

        // Digit k is a leading zero when it and every digit above it are zero.
        all_zero = 1'b1;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
`ifdef SEG7_BLINK_EN
        cur_blink = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (active_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                cur_nib = active_q[4*k +: 4];
                cur_dp  = dp_in[k];
                cur_lz  = all_zero && (k != 0);
`ifdef SEG7_BLINK_EN
                cur_blink = blink[k];
`endif
            end
        end

`ifdef SEG7_BLINK_EN
        blink_off  = cur_blink && !phase_on_q;
        frm_d      = frm_q;
        phase_on_d = phase_on_q;
        if (wrap) begin
            frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
            if (frm_q == FRM_LAST) begin
                phase_on_d = !phase_on_q;
            end
        end
`else
        blink_off = 1'b0;
`endif

        seg_d        = seg_q;
        dp_d         = dp_q;
        an_d         = an_q;
        frame_tick_d = tick && (idx_q == '0);
        if (tick) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = ((blank_lz && cur_lz) || blink_off) ? 7'h7F : hex_to_seg(cur_nib);
            dp_d  = blink_off ? 1'b1 : !cur_dp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
`ifdef SEG7_BLINK_EN
            frm_q        <= '0;
            phase_on_q   <= 1'b1;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG7_BLINK_EN
            frm_q        <= frm_d;
            phase_on_q   <= phase_on_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
